div_sched: RTL

- Schedules and shares one sequential 8/4 shift-subtract divider among N_REQ requesters.
- Per request: accepts operands, screens out divide-by-zero and quotient overflow, launches the divider, then tracks its ready handshake to completion.
- Returns quotient, remainder, requester ID and error flag on a single valid/ready response bus.
- Sits between client blocks and the divider instance; it is the only driver of the divider's start and operand inputs.

---
 rtl/div_sched_pkg.sv | 22 ++
 rtl/div_rr_arbiter.sv | 37 +++
 rtl/div_sched.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/div_sched_pkg.sv
// rtl/div_sched_pkg.sv - shared types, constants and operand screening for div_sched
package div_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_RESP
    } state_t;

    // Response fields reported for any error (div-by-zero, overflow, timeout).
    localparam logic [3:0] ERR_QUOT = 4'hF;
    localparam logic [3:0] ERR_REM  = 4'h0;

    // A 4-bit quotient cannot hold D/V when the upper dividend nibble is
    // already >= V; V == 0 is rejected the same way.
    function automatic logic div_bad(input logic [7:0] d, input logic [3:0] v);
        return (v == 4'd0) || (d[7:4] >= v);
    endfunction

endpackage

// File: rtl/div_rr_arbiter.sv
// rtl/div_rr_arbiter.sv - combinational round-robin grant among N_REQ requesters
//
// Ports:
//   req        in   N_REQ  request vector
//   ptr        in   IW     priority pointer; search starts here and wraps
//   grant      out  N_REQ  one-hot grant (zero when no request)
//   grant_idx  out  IW     index of the granted requester
//   any_valid  out  1      at least one request present
module div_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    grant_idx,
    output logic             any_valid
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!any_valid && req[idx]) begin
                any_valid      = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/div_sched.sv
// rtl/div_sched.sv - schedules one shared sequential 8/4 divider among N_REQ requesters
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   req_valid/req_ready        per-requester handshake (req_ready one-hot or zero)
//   req_dividend/req_divisor   packed operands, requester i at [8i+7:8i] / [4i+3:4i]
//   resp_valid/resp_ready      response handshake
//   resp_id/quotient/remainder/err  response fields, held until accepted
//   div_start/div_word1/div_word2   divider launch controls
//   div_quotient/div_remainder/div_ready  divider results and idle/done flag
module div_sched
    import div_sched_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [8*N_REQ-1:0] req_dividend,
    input  logic [4*N_REQ-1:0] req_divisor,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [ID_W-1:0]    resp_id,
    output logic [3:0]         resp_quotient,
    output logic [3:0]         resp_remainder,
    output logic               resp_err,
    output logic               div_start,
    output logic [7:0]         div_word1,
    output logic [3:0]         div_word2,
    input  logic [3:0]         div_quotient,
    input  logic [3:0]         div_remainder,
    input  logic               div_ready
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    state_t            state, state_nxt;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   gid;
    logic [CW-1:0]     wait_cnt;
    logic [7:0]        op_d;
    logic [3:0]        op_v;
    logic [3:0]        rq, rr;
    logic              re;

    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_idx;
    logic              any_valid;
    logic [7:0]        dvd [N_REQ];
    logic [3:0]        dvs [N_REQ];
    logic [7:0]        sel_d;
    logic [3:0]        sel_v;
    logic              bad;
    logic              wait_last;
    logic              timeout;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign dvd[i] = req_dividend[8*i +: 8];
        assign dvs[i] = req_divisor[4*i +: 4];
    end

    div_rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

    assign sel_d     = dvd[grant_idx];
    assign sel_v     = dvs[grant_idx];
    assign bad       = div_bad(sel_d, sel_v);
    assign wait_last = (wait_cnt == CW'(MAX_WAIT - 1));

    assign div_word1      = op_d;
    assign div_word2      = op_v;
    assign resp_id        = gid;
    assign resp_quotient  = rq;
    assign resp_remainder = rr;
    assign resp_err       = re;

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        div_start  = 1'b0;
        resp_valid = 1'b0;
        timeout    = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = grant;
                if (any_valid) begin
                    state_nxt = bad ? ST_RESP : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                // Held high until the divider is seen idle; a busy divider
                // ignores start, so repeating it is harmless.
                div_start = 1'b1;
                if (div_ready) begin
                    state_nxt = ST_WAIT_BUSY;
                end else if (wait_last) begin
                    timeout   = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_WAIT_BUSY: begin
                if (!div_ready) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (wait_last) begin
                    timeout   = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_WAIT_DONE: begin
                if (div_ready) begin
                    state_nxt = ST_RESP;
                end else if (wait_last) begin
                    timeout   = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            gid      <= '0;
            wait_cnt <= '0;
            op_d     <= '0;
            op_v     <= '0;
            rq       <= '0;
            rr       <= '0;
            re       <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state_nxt != state) begin
                wait_cnt <= '0;
            end else if (state == ST_LAUNCH || state == ST_WAIT_BUSY || state == ST_WAIT_DONE) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        gid <= grant_idx;
                        if (bad) begin
                            re <= 1'b1;
                            rq <= ERR_QUOT;
                            rr <= ERR_REM;
                        end else begin
                            // Only launched operands reach the divider bus,
                            // so rejected requests leave div_word* untouched.
                            op_d <= sel_d;
                            op_v <= sel_v;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (div_ready) begin
                        re <= 1'b0;
                        rq <= div_quotient;
                        rr <= div_remainder;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        ptr <= (gid == ID_W'(N_REQ - 1)) ? '0 : gid + 1'b1;
                    end
                end
                default: ;
            endcase

            if (timeout) begin
                re <= 1'b1;
                rq <= ERR_QUOT;
                rr <= ERR_REM;
            end
        end
    end

endmodule
